axis_byte_source: RTL and testbench

AXI4-Stream master that generates a programmed burst of 8-bit beats: an incrementing byte pattern from a seed, with a configurable number of idle cycles after each beat. It is the transmitting end of the 8-bit AXI4-Stream slave link in our testbenches. Its `m_axis_*` port drives the slave VIP's `s_axis_*` (tvalid/tready/tdata only) directly, so stimulus can be produced in RTL without a master VIP.

---
 rtl/axis_byte_source.sv | 120 ++++++++++++
 tb/tb_axis_byte_source.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_source.sv
// rtl/axis_byte_source.sv - AXI4-Stream master emitting a seeded incrementing byte burst
// Programmable beat count and idle gap after every non-last beat; all outputs registered.
module axis_byte_source #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       seed,
  input  logic [GAP_W-1:0] idle_cycles,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beats,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [7:0]       m_axis_tdata
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [LEN_W-1:0] beats_inc;

  assign beats_inc = beats_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beats_d   = beats_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          beats_d = '0;
          if (len != '0) begin
            len_d     = len;
            gap_len_d = idle_cycles;
            tdata_d   = seed;
            tvalid_d  = 1'b1;
            state_d   = SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (tvalid_q && m_axis_tready) begin
          beats_d = beats_inc;
          if (beats_inc == len_q) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            tdata_d = tdata_q + 8'd1;
            if (gap_len_q != '0) begin
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_len_q;
              state_d   = GAP;
            end
          end
        end
      end
      GAP: begin
        // tvalid rises on the edge that consumes the final idle cycle
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          tvalid_d = 1'b1;
          state_d  = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beats_q   <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      tdata_q   <= 8'h00;
      tvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beats_q   <= beats_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign beats         = beats_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_byte_source.sv
// tb/tb_axis_byte_source.sv - randomized self-checking bench for axis_byte_source
// Expected bursts come from the arithmetic rule data[i] = seed + i with fixed gaps.
module tb_axis_byte_source;
  localparam int LEN_W = 16;
  localparam int GAP_W = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       seed = 8'h00;
  logic [GAP_W-1:0] idle_cycles = '0;
  logic             busy, done;
  logic [LEN_W-1:0] beats;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic [7:0]       m_axis_tdata;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_byte_source #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .len(len), .seed(seed),
    .idle_cycles(idle_cycles), .busy(busy), .done(done), .beats(beats),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata)
  );

  logic [7:0]       obs_data[$];
  int               obs_gap[$];
  int               first_valid, last_hs, done_cyc, done_cnt, stab_err, stall_cyc;
  int               busy_err, post_rst_bad, after_done_valid;
  logic [LEN_W-1:0] obs_beats;

  function automatic logic [7:0] exp_byte(input logic [7:0] s, input int i);
    return 8'((int'(s) + i) & 255);
  endfunction

  // Runs one burst cycle by cycle (cycle 0 follows the edge that samples start) and records what the link did.
  task automatic drive_burst(input logic [7:0] s, input int l, input int g, input int ready_pct,
                             input int stall_beat, input int stall_len, input int mid_start,
                             input int rst_at_hs, input int max_cyc);
    int   hs = 0;
    int   low_run = 0;
    bit   after_hs = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    int   stall_rem = stall_len;
    int   rst_cyc = -1;
    bit   hsn;
    obs_data.delete();
    obs_gap.delete();
    first_valid = -1; last_hs = -1; done_cyc = -1; done_cnt = 0; stab_err = 0;
    stall_cyc = 0; busy_err = 0; post_rst_bad = 0; after_done_valid = 0;
    @(posedge aclk); #1;
    start = 1'b1; len = LEN_W'(l); seed = s; idle_cycles = GAP_W'(g);
    for (int c = -1; c < max_cyc; c++) begin
      if (c >= 0) begin
        start = (c == mid_start);
        if (c == mid_start) begin len = LEN_W'(2); seed = 8'h55; end
        aresetn = (c != rst_cyc);
        if (hs == stall_beat && stall_rem > 0) begin
          m_axis_tready = 1'b0;
          stall_rem--;
        end else begin
          m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        end
      end
      @(negedge aclk);
      if (c >= 0) begin
        hsn = m_axis_tvalid && m_axis_tready && aresetn;
        if (done) begin done_cnt++; done_cyc = c; end
        if (done && busy) busy_err++;
        if (m_axis_tvalid && done_cyc >= 0) after_done_valid++;
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data)) stab_err++;
        if (m_axis_tvalid && first_valid < 0) first_valid = c;
        if (m_axis_tvalid && after_hs) begin obs_gap.push_back(low_run); after_hs = 0; end
        if (!m_axis_tvalid && after_hs) low_run++;
        if (m_axis_tvalid && !m_axis_tready) stall_cyc++;
        if (rst_cyc < 0 && done_cyc < 0 && hs < l && !busy) busy_err++;
        if (hsn) begin
          obs_data.push_back(m_axis_tdata);
          hs++; last_hs = c; after_hs = 1; low_run = 0;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (rst_at_hs >= 0 && hs == rst_at_hs && rst_cyc < 0) rst_cyc = c + 1;
        if (rst_cyc >= 0 && c > rst_cyc && (m_axis_tvalid || done || beats != '0)) post_rst_bad++;
        if (done_cyc >= 0 && c >= done_cyc + 2) break;
      end
      @(posedge aclk); #1;
    end
    obs_beats = beats;
    start = 1'b0;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (beats !== '0) begin errors++; $display("FAIL reset_beats: got %0d want 0", beats); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_basic();
    drive_burst(8'h10, 4, 0, 100, -1, 0, -1, -1, 40);
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", obs_data.size()); end
    foreach (obs_data[i]) begin
      checks++;
      if (obs_data[i] !== exp_byte(8'h10, i)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, obs_data[i], exp_byte(8'h10, i)); end
    end
    checks++; if (first_valid != 0) begin errors++; $display("FAIL basic_latency: got %0d want 0", first_valid); end
    checks++; if (last_hs != 3) begin errors++; $display("FAIL basic_last_cycle: got %0d want 3", last_hs); end
    checks++; if (done_cyc != 4 || done_cnt != 1) begin errors++; $display("FAIL basic_done: cycle %0d count %0d want 4/1", done_cyc, done_cnt); end
    checks++; if (obs_beats !== 16'd4) begin errors++; $display("FAIL basic_beats: got %0d want 4", obs_beats); end
    checks++; if (busy_err != 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles want 0", busy_err); end
  endtask

  task automatic test_backpressure();
    drive_burst(8'hA0, 3, 0, 100, 1, 5, -1, -1, 40);
    checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", obs_data.size()); end
    foreach (obs_data[i]) begin
      checks++;
      if (obs_data[i] !== exp_byte(8'hA0, i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data[i], exp_byte(8'hA0, i)); end
    end
    checks++; if (stall_cyc != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_cyc); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); end
    checks++; if (done_cyc != last_hs + 1 || done_cnt != 1) begin errors++; $display("FAIL bp_done: cycle %0d count %0d want %0d/1", done_cyc, done_cnt, last_hs + 1); end
  endtask

  task automatic test_wrap_gaps();
    drive_burst(8'hFE, 3, 2, 100, -1, 0, -1, -1, 40);
    checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d want 3", obs_data.size()); end
    foreach (obs_data[i]) begin
      checks++;
      if (obs_data[i] !== exp_byte(8'hFE, i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, obs_data[i], exp_byte(8'hFE, i)); end
    end
    checks++; if (obs_gap.size() != 2) begin errors++; $display("FAIL wrap_gap_count: got %0d want 2", obs_gap.size()); end
    foreach (obs_gap[i]) begin
      checks++;
      if (obs_gap[i] != 2) begin errors++; $display("FAIL wrap_gap[%0d]: got %0d want 2", i, obs_gap[i]); end
    end
    checks++; if (done_cyc != last_hs + 1 || done_cnt != 1) begin errors++; $display("FAIL wrap_done: cycle %0d count %0d want %0d/1", done_cyc, done_cnt, last_hs + 1); end
  endtask

  task automatic test_zero_len();
    drive_burst(8'($urandom), 0, 1, 100, -1, 0, -1, -1, 20);
    checks++; if (first_valid != -1) begin errors++; $display("FAIL zero_tvalid: tvalid seen at cycle %0d want never", first_valid); end
    checks++; if (done_cyc != 0 || done_cnt != 1) begin errors++; $display("FAIL zero_done: cycle %0d count %0d want 0/1", done_cyc, done_cnt); end
    checks++; if (obs_beats !== '0) begin errors++; $display("FAIL zero_beats: got %0d want 0", obs_beats); end
  endtask

  task automatic test_ignored_start();
    logic [7:0] s = 8'($urandom);
    drive_burst(s, 5, 1, 100, -1, 0, 3, -1, 60);
    checks++; if (obs_data.size() != 5) begin errors++; $display("FAIL ign_count: got %0d want 5", obs_data.size()); end
    foreach (obs_data[i]) begin
      checks++;
      if (obs_data[i] !== exp_byte(s, i)) begin errors++; $display("FAIL ign_data[%0d]: got %h want %h", i, obs_data[i], exp_byte(s, i)); end
    end
    checks++; if (done_cnt != 1 || after_done_valid != 0) begin errors++; $display("FAIL ign_done: count %0d late tvalid %0d want 1/0", done_cnt, after_done_valid); end
    checks++; if (obs_beats !== 16'd5) begin errors++; $display("FAIL ign_beats: got %0d want 5", obs_beats); end
  endtask

  task automatic test_reset_mid();
    drive_burst(8'($urandom), 8, 0, 100, -1, 0, -1, 3, 20);
    checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL rst_count: got %0d want 3", obs_data.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt); end
    checks++; if (post_rst_bad != 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", post_rst_bad); end
    drive_burst(8'h00, 2, 0, 100, -1, 0, -1, -1, 30);
    checks++; if (obs_data.size() != 2) begin errors++; $display("FAIL rst_after_count: got %0d want 2", obs_data.size()); end
    foreach (obs_data[i]) begin
      checks++;
      if (obs_data[i] !== exp_byte(8'h00, i)) begin errors++; $display("FAIL rst_after_data[%0d]: got %h want %h", i, obs_data[i], exp_byte(8'h00, i)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_after_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s1 = 8'($urandom);
    logic [7:0] s2 = 8'($urandom);
    int l1 = $urandom_range(1, 4);
    int l2 = $urandom_range(1, 4);
    logic [7:0] d[$];
    int rise = -1;
    int dc = -1;
    int dcnt = 0;
    @(posedge aclk); #1;
    start = 1'b1; len = LEN_W'(l1); seed = s1; idle_cycles = '0; m_axis_tready = 1'b1;
    for (int c = -1; c < l1 + l2 + 6; c++) begin
      if (c >= 0) begin
        start = (c == l1);
        if (c == l1) begin len = LEN_W'(l2); seed = s2; end
      end
      @(negedge aclk);
      if (c >= 0) begin
        if (done) begin dcnt++; if (dc < 0) dc = c; end
        if (m_axis_tvalid && c > l1 && rise < 0) rise = c;
        if (m_axis_tvalid && m_axis_tready) d.push_back(m_axis_tdata);
      end
      @(posedge aclk); #1;
    end
    start = 1'b0;
    checks++; if (dc != l1) begin errors++; $display("FAIL b2b_first_done: got %0d want %0d", dc, l1); end
    checks++; if (rise != dc + 1) begin errors++; $display("FAIL b2b_rise: got %0d want %0d", rise, dc + 1); end
    checks++; if (dcnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
    checks++; if (d.size() != l1 + l2) begin errors++; $display("FAIL b2b_count: got %0d want %0d", d.size(), l1 + l2); end
    foreach (d[i]) begin
      checks++;
      if (i < l1 && d[i] !== exp_byte(s1, i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, d[i], exp_byte(s1, i)); end
      else if (i >= l1 && d[i] !== exp_byte(s2, i - l1)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, d[i], exp_byte(s2, i - l1)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] s = 8'($urandom);
      int l = $urandom_range(1, 12);
      int g = $urandom_range(0, 3);
      drive_burst(s, l, g, 60, -1, 0, -1, -1, 60 + l * (g + 1) * 6);
      checks++; if (obs_data.size() != l) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", n, obs_data.size(), l); end
      foreach (obs_data[i]) begin
        checks++;
        if (obs_data[i] !== exp_byte(s, i)) begin errors++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", n, i, obs_data[i], exp_byte(s, i)); end
      end
      foreach (obs_gap[i]) begin
        checks++;
        if (obs_gap[i] != g) begin errors++; $display("FAIL rnd%0d_gap[%0d]: got %0d want %0d", n, i, obs_gap[i], g); end
      end
      checks++; if (first_valid != 0) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 0", n, first_valid); end
      checks++; if (done_cyc != last_hs + 1 || done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done: cycle %0d count %0d want %0d/1", n, done_cyc, done_cnt, last_hs + 1); end
      checks++; if (obs_beats !== LEN_W'(l)) begin errors++; $display("FAIL rnd%0d_beats: got %0d want %0d", n, obs_beats, l); end
      checks++; if (stab_err != 0 || busy_err != 0) begin errors++; $display("FAIL rnd%0d_protocol: unstable %0d busy %0d want 0/0", n, stab_err, busy_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_gaps();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
